// File: rtl/vector_ram_arbiter_if.sv
// Request/response bundle between the vector RAM requesters, the arbiter and the RAM macro.
// slave = arbiter side, master = requester/RAM side.
interface vector_ram_arbiter_if #(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 7
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;

  logic                  ram_write_enable;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_in;
  logic [DATA_WIDTH-1:0] ram_out;

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_addr,
    input  ram_out,
    output wr_ready, rd_ready, rd_data, rd_data_valid,
    output ram_write_enable, ram_addr, ram_in
  );

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_valid, rd_addr,
    output ram_out,
    input  wr_ready, rd_ready, rd_data, rd_data_valid,
    input  ram_write_enable, ram_addr, ram_in
  );
endinterface

// File: rtl/vector_ram_arbiter.sv
// Round-robin arbiter giving one writer and one reader shared access to a single-port vector RAM.
// Optional feature macro VRAM_CLEAR_EN adds a clear sweep that zeroes every RAM entry.
module vector_ram_arbiter #(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 7
) (
  input  logic clk,
  input  logic rst_n,
`ifdef VRAM_CLEAR_EN
  input  logic clear_start,
  output logic busy,
  output logic clear_done,
`endif
  vector_ram_arbiter_if.slave bus
);

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;

  grant_t                lastGrant_q;
  grant_t                lastGrant_d;
  logic                  rdDataValid_q;
  logic                  grantWr;
  logic                  grantRd;
  logic                  inIdle;
  logic                  ramWe;
  logic [ADDR_WIDTH-1:0] ramAddr;
  logic [DATA_WIDTH-1:0] ramIn;

`ifdef VRAM_CLEAR_EN
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] clearCnt_q;
  logic [ADDR_WIDTH-1:0] clearCnt_d;
  logic                  clearDone_q;
  logic                  clearDone_d;

  assign inIdle = (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clearCnt_q  <= '0;
      clearDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clearCnt_q  <= clearCnt_d;
      clearDone_q <= clearDone_d;
    end
  end

  // The counter wraps back to zero on the last sweep write, so every sweep starts at address 0.
  always_comb begin
    state_d     = state_q;
    clearCnt_d  = clearCnt_q;
    clearDone_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clearCnt_d = clearCnt_q + 1'b1;
        if (clearCnt_q == '1) begin
          state_d     = IDLE;
          clearDone_d = 1'b1;
        end
      end
    endcase
  end

  assign busy       = (state_q == CLEAR);
  assign clear_done = clearDone_q;
`else
  assign inIdle = 1'b1;
`endif

  // Readies are gated by rst_n so they are low while reset is held, even though they are combinational.
  always_comb begin
    grantWr = 1'b0;
    grantRd = 1'b0;
    if (rst_n && inIdle) begin
      if (bus.wr_valid && (!bus.rd_valid || (lastGrant_q == GRANT_RD))) begin
        grantWr = 1'b1;
      end else if (bus.rd_valid) begin
        grantRd = 1'b1;
      end
    end
  end

  always_comb begin
    lastGrant_d = lastGrant_q;
    if (grantWr) begin
      lastGrant_d = GRANT_WR;
    end else if (grantRd) begin
      lastGrant_d = GRANT_RD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrant_q   <= GRANT_RD;
      rdDataValid_q <= 1'b0;
    end else begin
      lastGrant_q   <= lastGrant_d;
      rdDataValid_q <= grantRd;
    end
  end

  always_comb begin
    ramWe   = 1'b0;
    ramAddr = '0;
    ramIn   = '0;
    if (grantWr) begin
      ramWe   = 1'b1;
      ramAddr = bus.wr_addr;
      ramIn   = bus.wr_data;
    end else if (grantRd) begin
      ramAddr = bus.rd_addr;
    end
`ifdef VRAM_CLEAR_EN
    if (state_q == CLEAR) begin
      ramWe   = 1'b1;
      ramAddr = clearCnt_q;
      ramIn   = '0;
    end
`endif
  end

  assign bus.wr_ready         = grantWr;
  assign bus.rd_ready         = grantRd;
  assign bus.rd_data_valid    = rdDataValid_q;
  assign bus.rd_data          = bus.ram_out;
  assign bus.ram_write_enable = ramWe;
  assign bus.ram_addr         = ramAddr;
  assign bus.ram_in           = ramIn;

  assert property (@(posedge clk) disable iff (!rst_n) !(bus.wr_ready && bus.rd_ready));
  assert property (@(posedge clk) disable iff (!rst_n) grantRd |=> rdDataValid_q);

endmodule

// File: tb/tb_vector_ram_arbiter.sv
// Bench for vector_ram_arbiter: behavioural RAM plus a read-data scoreboard fed from a reference memory.
// Clear-sweep scenarios run only when VRAM_CLEAR_EN is defined.
module tb_vector_ram_arbiter;
  localparam int DW    = 128;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef VRAM_CLEAR_EN
  logic clearStart = 1'b0;
  logic busy;
  logic clearDone;
`endif

  vector_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef VRAM_CLEAR_EN
    .clear_start(clearStart),
    .busy       (busy),
    .clear_done (clearDone),
`endif
    .bus        (bus)
  );

  // Behavioural single-port RAM with one cycle of registered read latency.
  logic [DW-1:0] ramMem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_write_enable) ramMem[bus.ram_addr] <= bus.ram_in;
    bus.ram_out <= ramMem[bus.ram_addr];
  end

  logic [DW-1:0] refMem [DEPTH];
  logic [DW-1:0] expQ [$];
  int totalChecks = 0;
  int badChecks   = 0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic rv, input logic [AW-1:0] ra);
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_valid = rv;
    bus.rd_addr  = ra;
  endtask

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // Read results come back in grant order, so a FIFO of expected words is enough.
  task automatic scoreboard();
    logic [DW-1:0] expData;
    if (!rst_n) return;
    if (bus.rd_data_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_unexpected_valid", DW'(1), DW'(0));
      end else begin
        expData = expQ.pop_front();
        checkOutput("sb_rd_data", bus.rd_data, expData);
      end
    end
    if (bus.rd_valid && bus.rd_ready) expQ.push_back(refMem[bus.rd_addr]);
    if (bus.wr_valid && bus.wr_ready) refMem[bus.wr_addr] = bus.wr_data;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    scoreboard();
  endtask

  task automatic nextDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    rst_n = 1'b0;
    expQ.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic readSweep(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, AW'(i));
      stepCycle();
      checkOutput({tag, "_rd_ready"}, DW'(bus.rd_ready), DW'(1));
      if (i > 0) checkOutput({tag, "_valid_run"}, DW'(bus.rd_data_valid), DW'(1));
      nextDrive();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    stepCycle();
    checkOutput({tag, "_last_valid"}, DW'(bus.rd_data_valid), DW'(1));
    nextDrive();
    stepCycle();
    checkOutput({tag, "_valid_end"}, DW'(bus.rd_data_valid), DW'(0));
    checkOutput({tag, "_sb_drained"}, DW'(expQ.size()), DW'(0));
    nextDrive();
  endtask

  initial begin
    logic [3:0]    expW;
    logic [3:0]    expV;
    logic [DW-1:0] patA5;
    logic          tbLastRd;
    logic          wv, rv, expWr, expRd;
    int            doneSeen;

    patA5 = {(DW / 8){8'hA5}};
    expW  = 4'b0101;
    expV  = 4'b0100;

    // Valids held high while in reset: everything must stay quiet.
    applyStimulus(1'b1, AW'(3), patA5, 1'b1, AW'(4));
    @(negedge clk);
    checkOutput("rst_wr_ready", DW'(bus.wr_ready), DW'(0));
    checkOutput("rst_rd_ready", DW'(bus.rd_ready), DW'(0));
    checkOutput("rst_rd_valid", DW'(bus.rd_data_valid), DW'(0));
    checkOutput("rst_ram_we", DW'(bus.ram_write_enable), DW'(0));
    checkOutput("rst_ram_addr", DW'(bus.ram_addr), DW'(0));
    checkOutput("rst_ram_in", bus.ram_in, DW'(0));
`ifdef VRAM_CLEAR_EN
    checkOutput("rst_busy", DW'(busy), DW'(0));
    checkOutput("rst_clear_done", DW'(clearDone), DW'(0));
`endif
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single write straight after reset.
    applyStimulus(1'b1, AW'(5), patA5, 1'b0, '0);
    stepCycle();
    checkOutput("wr_grant_ready", DW'(bus.wr_ready), DW'(1));
    checkOutput("wr_grant_rd_ready", DW'(bus.rd_ready), DW'(0));
    checkOutput("wr_grant_we", DW'(bus.ram_write_enable), DW'(1));
    checkOutput("wr_grant_addr", DW'(bus.ram_addr), DW'(5));
    checkOutput("wr_grant_data", bus.ram_in, patA5);
    nextDrive();
    applyStimulus(1'b0, AW'(5), patA5, 1'b0, AW'(6));
    stepCycle();
    checkOutput("idle_we", DW'(bus.ram_write_enable), DW'(0));
    checkOutput("idle_addr", DW'(bus.ram_addr), DW'(0));
    checkOutput("idle_in", bus.ram_in, DW'(0));
    checkOutput("idle_wr_ready", DW'(bus.wr_ready), DW'(0));
    nextDrive();

    // Both requesters contending from reset: W,R,W,R.
    resetDut();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, AW'(20 + k), randData(), 1'b1, AW'(5));
      stepCycle();
      checkOutput("rr_wr_ready", DW'(bus.wr_ready), DW'(expW[k]));
      checkOutput("rr_rd_ready", DW'(bus.rd_ready), DW'(!expW[k]));
      checkOutput("rr_rd_valid", DW'(bus.rd_data_valid), DW'(expV[k]));
      nextDrive();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    stepCycle();
    checkOutput("rr_rd_valid5", DW'(bus.rd_data_valid), DW'(1));
    nextDrive();

    // Read-after-write on consecutive cycles.
    applyStimulus(1'b1, AW'(9), DW'(16'h1234), 1'b0, '0);
    stepCycle();
    checkOutput("raw_wr_ready", DW'(bus.wr_ready), DW'(1));
    nextDrive();
    applyStimulus(1'b0, '0, '0, 1'b1, AW'(9));
    stepCycle();
    checkOutput("raw_rd_ready", DW'(bus.rd_ready), DW'(1));
    checkOutput("raw_rd_addr", DW'(bus.ram_addr), DW'(9));
    nextDrive();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    stepCycle();
    checkOutput("raw_rd_valid", DW'(bus.rd_data_valid), DW'(1));
    checkOutput("raw_rd_data", bus.rd_data, DW'(16'h1234));
    nextDrive();

    // Fill every entry, then stream all of them back.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, AW'(i), randData(), 1'b0, '0);
      stepCycle();
      checkOutput("fill_wr_ready", DW'(bus.wr_ready), DW'(1));
      nextDrive();
    end
    readSweep("sweep");

    // Random contention against an independent round-robin expectation.
    resetDut();
    tbLastRd = 1'b1;
    for (int n = 0; n < 300; n++) begin
      wv = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      expWr = wv && (!rv || tbLastRd);
      expRd = rv && !expWr;
      applyStimulus(wv, AW'($urandom_range(0, DEPTH - 1)), randData(), rv, AW'($urandom_range(0, DEPTH - 1)));
      stepCycle();
      checkOutput("rand_wr_ready", DW'(bus.wr_ready), DW'(expWr));
      checkOutput("rand_rd_ready", DW'(bus.rd_ready), DW'(expRd));
      if (expWr) tbLastRd = 1'b0;
      else if (expRd) tbLastRd = 1'b1;
      nextDrive();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    stepCycle();
    nextDrive();
    stepCycle();
    checkOutput("rand_sb_drained", DW'(expQ.size()), DW'(0));
    nextDrive();

`ifdef VRAM_CLEAR_EN
    // Clear sweep with a writer held valid throughout; a late clear_start must be ignored.
    applyStimulus(1'b1, AW'(3), '0, 1'b0, '0);
    clearStart = 1'b1;
    stepCycle();
    checkOutput("clr_start_grant", DW'(bus.wr_ready), DW'(1));
    checkOutput("clr_start_busy", DW'(busy), DW'(0));
    nextDrive();
    for (int c = 0; c < DEPTH; c++) begin
      clearStart = (c == 60);
      stepCycle();
      checkOutput("clr_busy", DW'(busy), DW'(1));
      checkOutput("clr_wr_ready", DW'(bus.wr_ready), DW'(0));
      checkOutput("clr_we", DW'(bus.ram_write_enable), DW'(1));
      checkOutput("clr_addr", DW'(bus.ram_addr), DW'(AW'(c)));
      checkOutput("clr_in", bus.ram_in, DW'(0));
      checkOutput("clr_done_early", DW'(clearDone), DW'(0));
      nextDrive();
    end
    clearStart = 1'b0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
    stepCycle();
    checkOutput("clr_done_pulse", DW'(clearDone), DW'(1));
    checkOutput("clr_done_busy", DW'(busy), DW'(0));
    checkOutput("clr_done_wr_grant", DW'(bus.wr_ready), DW'(1));
    nextDrive();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    stepCycle();
    checkOutput("clr_done_once", DW'(clearDone), DW'(0));
    nextDrive();
    readSweep("zero");

    // Reset in the middle of a sweep aborts it.
    clearStart = 1'b1;
    stepCycle();
    nextDrive();
    clearStart = 1'b0;
    for (int c = 0; c < 50; c++) begin
      stepCycle();
      nextDrive();
    end
    stepCycle();
    checkOutput("abort_busy_before", DW'(busy), DW'(1));
    checkOutput("abort_addr_before", DW'(bus.ram_addr), DW'(50));
    #1;
    rst_n = 1'b0;
    applyStimulus(1'b1, AW'(7), randData(), 1'b1, AW'(8));
    expQ.delete();
    #1;
    checkOutput("abort_wr_ready", DW'(bus.wr_ready), DW'(0));
    checkOutput("abort_rd_ready", DW'(bus.rd_ready), DW'(0));
    checkOutput("abort_rd_valid", DW'(bus.rd_data_valid), DW'(0));
    checkOutput("abort_we", DW'(bus.ram_write_enable), DW'(0));
    checkOutput("abort_addr", DW'(bus.ram_addr), DW'(0));
    checkOutput("abort_in", bus.ram_in, DW'(0));
    checkOutput("abort_busy", DW'(busy), DW'(0));
    checkOutput("abort_done", DW'(clearDone), DW'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stepCycle();
    checkOutput("post_rst_wr_ready", DW'(bus.wr_ready), DW'(1));
    checkOutput("post_rst_rd_ready", DW'(bus.rd_ready), DW'(0));
    checkOutput("post_rst_we", DW'(bus.ram_write_enable), DW'(1));
    checkOutput("post_rst_addr", DW'(bus.ram_addr), DW'(7));
    nextDrive();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    doneSeen = 0;
    for (int n = 0; n < 200; n++) begin
      stepCycle();
      if (clearDone) doneSeen++;
      nextDrive();
    end
    checkOutput("abort_no_done", DW'(doneSeen), DW'(0));
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
